matrix_mem: RTL and testbench

MATRIX_MEM -- requirements
Module: matrix_mem

---
 rtl/matrix_mem.sv | 137 +++++++++++++
 tb/tb_matrix_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem.sv
// Dual-read, single-write matrix storage with a power-on clear sequence,
// masked element writes, write-first bypass and an optional transposed read on port 1.
module matrix_mem #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  localparam int unsigned NE    = DIM * DIM,
  localparam int unsigned MW    = ELEM_W * NE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_xpose1,
  output logic [MW-1:0]     rd_data1,
  output logic              rd_valid1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [MW-1:0]     rd_data2,
  output logic              rd_valid2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MW-1:0]     wr_data,
  input  logic [NE-1:0]     wr_mask,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_d;
  logic [MW-1:0]     mem [DEPTH];

  logic          idle;
  logic          wr_in, rd_in1, rd_in2;
  logic          wr_ok, rd_ok1, rd_ok2, err_c;
  logic [MW-1:0] wr_old, wr_word;
  logic [MW-1:0] rd_word1, rd_xp1, rd_word2;

  // Next-state logic: walk the clear pointer across every entry, then idle
  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    case (state)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_A) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
    end
  end

  // Request qualification; nothing is accepted while clearing
  always_comb begin
    idle   = (state == ST_IDLE);
    wr_in  = ({1'b0, wr_addr}  < DEPTH_A);
    rd_in1 = ({1'b0, rd_addr1} < DEPTH_A);
    rd_in2 = ({1'b0, rd_addr2} < DEPTH_A);
    wr_ok  = idle && wr_en && wr_in;
    rd_ok1 = idle && rd_en1;
    rd_ok2 = idle && rd_en2;
    err_c  = idle && ((wr_en && !wr_in) || (rd_en1 && !rd_in1) || (rd_en2 && !rd_in2));
  end

  // Masked merge of the incoming word into the stored one
  always_comb begin
    wr_old = '0;
    if (wr_in) wr_old = mem[wr_addr];
    wr_word = wr_old;
    for (int unsigned k = 0; k < NE; k++) begin
      if (wr_mask[k]) wr_word[k*ELEM_W +: ELEM_W] = wr_data[k*ELEM_W +: ELEM_W];
    end
  end

  // Read data with write-first bypass; out-of-range reads return zero
  always_comb begin
    rd_word1 = '0;
    rd_word2 = '0;
    if (rd_in1) rd_word1 = (wr_ok && (wr_addr == rd_addr1)) ? wr_word : mem[rd_addr1];
    if (rd_in2) rd_word2 = (wr_ok && (wr_addr == rd_addr2)) ? wr_word : mem[rd_addr2];
    rd_xp1 = rd_word1;
    if (rd_xpose1) begin
      for (int unsigned r = 0; r < DIM; r++) begin
        for (int unsigned c = 0; c < DIM; c++) begin
          rd_xp1[(r*DIM+c)*ELEM_W +: ELEM_W] = rd_word1[(c*DIM+r)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data1  <= '0;
      rd_data2  <= '0;
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      busy      <= (state_d == ST_CLEAR);
      rd_valid1 <= rd_ok1;
      rd_valid2 <= rd_ok2;
      addr_err  <= err_c;
      if (rd_ok1) rd_data1 <= rd_xp1;
      if (rd_ok2) rd_data2 <= rd_word2;
    end
  end

  // Storage has no reset; the clear sequence provides the zero contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) mem[clr_ptr] <= '0;
      else if (wr_ok)        mem[wr_addr] <= wr_word;
    end
  end

endmodule

// File: tb/tb_matrix_mem.sv
// Directed table-driven bench for matrix_mem: a DEPTH=8 instance plus a DEPTH=6
// instance sharing the same stimulus for out-of-range address cases.
module tb_matrix_mem;

  localparam int unsigned MW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en1, rd_xpose1, rd_en2, wr_en;
  logic [2:0]    rd_addr1, rd_addr2, wr_addr;
  logic [MW-1:0] wr_data;
  logic [15:0]   wr_mask;

  logic [MW-1:0] rd_data1, rd_data2, d6_1, d6_2;
  logic          rd_valid1, rd_valid2, busy, addr_err;
  logic          v6_1, v6_2, busy_6, err6;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  matrix_mem dut (
    .clk(clk), .reset(reset),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_xpose1(rd_xpose1),
    .rd_data1(rd_data1), .rd_valid1(rd_valid1),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data2(rd_data2), .rd_valid2(rd_valid2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy), .addr_err(addr_err)
  );

  matrix_mem #(.DEPTH(6)) dut6 (
    .clk(clk), .reset(reset),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_xpose1(rd_xpose1),
    .rd_data1(d6_1), .rd_valid1(v6_1),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data2(d6_2), .rd_valid2(v6_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy_6), .addr_err(err6)
  );

  typedef struct {
    logic          re1;
    logic [2:0]    ra1;
    logic          xp;
    logic          re2;
    logic [2:0]    ra2;
    logic          we;
    logic [2:0]    wa;
    logic [MW-1:0] wd;
    logic [15:0]   wm;
    logic          ev1;
    logic [MW-1:0] ed1;
    logic          ev2;
    logic [MW-1:0] ed2;
    logic          eerr;
  } vec_t;

  vec_t tv[16];

  function automatic logic [MW-1:0] fill(input logic [15:0] v);
    logic [MW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = v;
    return w;
  endfunction

  // Row-major 1..16, and its transpose where element (r,c) = 4c+r+1
  function automatic logic [MW-1:0] seq_word(input bit xpose);
    logic [MW-1:0] w;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w[(r*4+c)*16 +: 16] = xpose ? 16'(4*c + r + 1) : 16'(4*r + c + 1);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    rd_en1 = 1'b0; rd_addr1 = '0; rd_xpose1 = 1'b0;
    rd_en2 = 1'b0; rd_addr2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  // Called at a negedge: releases reset with traffic on all ports for the first
  // few cycles, then measures how long each instance stays busy.
  task automatic wait_clear(input string tag);
    bit quiet;
    int n8, n6;
    quiet = 1'b1; n8 = 0; n6 = 0;
    reset = 1'b0;
    rd_en1 = 1'b1; rd_addr1 = 3'd0; rd_en2 = 1'b1; rd_addr2 = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = fill(16'hDEAD); wr_mask = '1;
    for (int cyc = 1; cyc <= 20 && n8 == 0; cyc++) begin
      @(posedge clk); #1;
      if (rd_valid1 || rd_valid2 || addr_err) quiet = 1'b0;
      if (!busy_6 && n6 == 0) n6 = cyc;
      if (!busy && n8 == 0) n8 = cyc;
      @(negedge clk);
      if (cyc >= 5) idle_inputs();
    end
    chk({tag, " quiet during clear"}, MW'(quiet), MW'(1));
    chk({tag, " busy cycles depth8"}, MW'(n8), MW'(8));
    chk({tag, " busy cycles depth6"}, MW'(n6), MW'(6));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] seq, seqt, mix, f1234;
    logic [MW-1:0] exp6 [6];

    seq   = seq_word(1'b0);
    seqt  = seq_word(1'b1);
    f1234 = fill(16'h1234);
    mix   = fill(16'h00AA);
    for (int k = 0; k < 4; k++) mix[k*16 +: 16] = 16'h0055;

    for (int i = 0; i < 8; i++)
      tv[i] = '{1'b1, 3'(i), 1'b0, 1'b1, 3'(i), 1'b0, 3'd0, '0, 16'h0,
                1'b1, '0, 1'b1, '0, 1'b0};
    tv[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, seq, 16'hFFFF,
               1'b0, '0, 1'b0, '0, 1'b0};
    tv[9]  = '{1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, '0, 16'h0,
               1'b1, seq, 1'b1, seq, 1'b0};
    tv[10] = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, '0, 16'h0,
               1'b1, seqt, 1'b0, seq, 1'b0};
    tv[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3, fill(16'h00AA), 16'hFFFF,
               1'b0, seqt, 1'b0, seq, 1'b0};
    tv[12] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, fill(16'h0055), 16'h000F,
               1'b0, seqt, 1'b1, mix, 1'b0};
    tv[13] = '{1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, '0, 16'h0,
               1'b1, mix, 1'b0, mix, 1'b0};
    tv[14] = '{1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 3'd5, f1234, 16'hFFFF,
               1'b1, f1234, 1'b1, f1234, 1'b0};
    tv[15] = '{1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4, seq, 16'hFFFF,
               1'b1, seqt, 1'b0, f1234, 1'b0};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    rd_en1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",      MW'(busy),      MW'(1));
    chk("reset rd_valid1", MW'(rd_valid1), MW'(0));
    chk("reset rd_valid2", MW'(rd_valid2), MW'(0));
    chk("reset rd_data1",  rd_data1,       '0);
    chk("reset rd_data2",  rd_data2,       '0);
    chk("reset addr_err",  MW'(addr_err),  MW'(0));
    @(negedge clk);
    wait_clear("init");

    // Table vectors on the DEPTH=8 instance
    for (int i = 0; i < 16; i++) begin
      rd_en1 = tv[i].re1; rd_addr1 = tv[i].ra1; rd_xpose1 = tv[i].xp;
      rd_en2 = tv[i].re2; rd_addr2 = tv[i].ra2;
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd; wr_mask = tv[i].wm;
      @(posedge clk); #1;
      chk($sformatf("v%0d rd_valid1", i), MW'(rd_valid1), MW'(tv[i].ev1));
      chk($sformatf("v%0d rd_data1", i),  rd_data1,       tv[i].ed1);
      chk($sformatf("v%0d rd_valid2", i), MW'(rd_valid2), MW'(tv[i].ev2));
      chk($sformatf("v%0d rd_data2", i),  rd_data2,       tv[i].ed2);
      chk($sformatf("v%0d addr_err", i),  MW'(addr_err),  MW'(tv[i].eerr));
      @(negedge clk);
      idle_inputs();
    end

    // Out-of-range read on DEPTH=6
    rd_en1 = 1'b1; rd_addr1 = 3'd7;
    @(posedge clk); #1;
    chk("d6 oor read valid", MW'(v6_1),     MW'(1));
    chk("d6 oor read data",  d6_1,          '0);
    chk("d6 oor read err",   MW'(err6),     MW'(1));
    chk("d8 addr7 no err",   MW'(addr_err), MW'(0));
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("d6 err pulse ends", MW'(err6), MW'(0));
    chk("d6 valid pulse ends", MW'(v6_1), MW'(0));
    @(negedge clk);

    // Three simultaneous errors on DEPTH=6 give one pulse; the write is dropped
    rd_en1 = 1'b1; rd_addr1 = 3'd7; rd_en2 = 1'b1; rd_addr2 = 3'd6;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = fill(16'hFFFF); wr_mask = '1;
    @(posedge clk); #1;
    chk("d6 multi err",     MW'(err6), MW'(1));
    chk("d6 oor rd2 valid", MW'(v6_2), MW'(1));
    chk("d6 oor rd2 data",  d6_2,      '0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("d6 multi err single pulse", MW'(err6), MW'(0));
    @(negedge clk);

    exp6[0] = '0; exp6[1] = '0; exp6[2] = seq; exp6[3] = mix; exp6[4] = seq; exp6[5] = f1234;
    for (int a = 0; a < 6; a++) begin
      rd_en1 = 1'b1; rd_addr1 = 3'(a);
      @(posedge clk); #1;
      chk($sformatf("d6 entry %0d", a), d6_1, exp6[a]);
      @(negedge clk);
    end
    idle_inputs();

    // One-cycle reset with a read in flight
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = fill(16'h7777); wr_mask = '1;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1; rd_en1 = 1'b1; rd_addr1 = 3'd1;
    @(posedge clk); #1;
    chk("mid reset rd_valid1", MW'(rd_valid1), MW'(0));
    chk("mid reset busy",      MW'(busy),      MW'(1));
    chk("mid reset rd_data1",  rd_data1,       '0);
    @(negedge clk);
    wait_clear("rerun");
    for (int a = 0; a < 8; a++) begin
      rd_en1 = 1'b1; rd_addr1 = 3'(a);
      @(posedge clk); #1;
      chk($sformatf("post reset entry %0d", a), rd_data1, '0);
      chk($sformatf("post reset valid %0d", a), MW'(rd_valid1), MW'(1));
      @(negedge clk);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
